// File: rtl/chip8_bus_reader.sv
// CHIP-8 host read-back responder: decodes 16-bit host reads, fetches two
// big-endian RAM bytes through the arbiter or samples a register, then pulses.
module chip8_bus_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        read,
    input  logic [11:0] address,
    output logic [15:0] readdata,
    output logic        readdatavalid,
    output logic        busy,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_sel,
    output logic [11:0] ch_addr,
    input  logic [7:0]  ch_q,
    output logic [7:0]  disp_addr,
    input  logic [7:0]  disp_q,
    input  logic [15:0] keystate,
    input  logic [15:0] status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_CAPT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [10:0] base_q, base_d;
    logic        first_q, first_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] readdata_q, readdata_d;

    logic        is_chip;
    logic        is_disp;
    logic        is_key;
    logic        is_stat;
    logic [15:0] reg_word;
    logic [7:0]  ram_byte;
    logic        odd;

    always_comb begin
        is_chip = ~address[11];
        is_disp = (address[11:7] == 5'b10000);
        is_key  = (address == 12'h880);
        is_stat = (address == 12'hFFF);
        reg_word = 16'h0000;
        unique case (1'b1)
            is_key:  reg_word = keystate;
            is_stat: reg_word = status;
            default: reg_word = 16'h0000;
        endcase
    end

    assign ram_byte = sel_q ? disp_q : ch_q;
    assign odd      = (state_q == S_ISSUE1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        base_d     = base_q;
        first_d    = 1'b0;
        hi_d       = hi_q;
        readdata_d = readdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (chipselect && read) begin
                    if (is_chip) begin
                        sel_d   = 1'b0;
                        base_d  = address[10:0];
                        state_d = S_ISSUE0;
                    end else if (is_disp) begin
                        sel_d   = 1'b1;
                        base_d  = {4'h0, address[6:0]};
                        state_d = S_ISSUE0;
                    end else begin
                        readdata_d = reg_word;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ISSUE0: begin
                if (mem_gnt) begin
                    first_d = 1'b1;
                    state_d = S_ISSUE1;
                end
            end
            S_ISSUE1: begin
                // even byte is only valid the cycle after its grant
                if (first_q) begin
                    hi_d = ram_byte;
                end
                if (mem_gnt) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                readdata_d = {hi_q, ram_byte};
                state_d    = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            base_q     <= 11'h000;
            first_q    <= 1'b0;
            hi_q       <= 8'h00;
            readdata_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            first_q    <= first_d;
            hi_q       <= hi_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = (state_q == S_RESP);
    assign busy          = (state_q != S_IDLE);
    assign mem_req       = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
    assign mem_sel       = sel_q;
    assign ch_addr       = {base_q, odd};
    assign disp_addr     = {base_q[6:0], odd};

endmodule

// File: tb/tb_chip8_bus_reader.sv
// Randomized bench for chip8_bus_reader with a memory/arbiter model and
// an address-map reference computed from the peripheral map.
module tb_chip8_bus_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic [11:0] address;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic        busy;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_sel;
    logic [11:0] ch_addr;
    logic [7:0]  ch_q;
    logic [7:0]  disp_addr;
    logic [7:0]  disp_q;
    logic [15:0] keystate;
    logic [15:0] status;

    chip8_bus_reader dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
        .address(address), .readdata(readdata),
        .readdatavalid(readdatavalid), .busy(busy), .mem_req(mem_req),
        .mem_gnt(mem_gnt), .mem_sel(mem_sel), .ch_addr(ch_addr),
        .ch_q(ch_q), .disp_addr(disp_addr), .disp_q(disp_q),
        .keystate(keystate), .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  chip_mem [4096];
    logic [7:0]  disp_mem [256];
    logic [63:0] gnt_vec = '1;
    int          cyc = 0;
    int          acc_cyc = -1000;
    logic        req_tr [64];
    logic        sel_tr [64];
    logic [11:0] adr_tr [64];
    logic        iss_v = 1'b0;
    logic        iss_sel = 1'b0;
    logic [11:0] iss_addr = '0;
    int          pulse_cnt = 0;
    int          glitch = 0;
    logic [15:0] prev_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data only for an issued read, garbage otherwise
    always @(posedge clk) begin
        ch_q <= (iss_v && !iss_sel) ? chip_mem[iss_addr] : 8'($urandom);
        disp_q <= (iss_v && iss_sel) ? disp_mem[iss_addr[7:0]]
                                     : 8'($urandom);
    end

    always @(negedge clk) begin
        int rel;
        rel = cyc - acc_cyc;
        mem_gnt = (rel >= 0 && rel < 64) ? gnt_vec[rel] : 1'b1;
        if (rel >= 1 && rel < 64) begin
            req_tr[rel] = mem_req;
            sel_tr[rel] = mem_sel;
            adr_tr[rel] = mem_sel ? {4'h0, disp_addr} : ch_addr;
        end
        iss_v    = mem_req && mem_gnt;
        iss_sel  = mem_sel;
        iss_addr = mem_sel ? {4'h0, disp_addr} : ch_addr;
        if (readdatavalid) pulse_cnt++;
        if (reset && !readdatavalid && readdata !== prev_rd) glitch++;
        prev_rd = readdata;
    end

    function automatic logic [15:0] model_word(input logic [11:0] a,
                                               input logic [15:0] ks,
                                               input logic [15:0] st);
        if (a < 12'h800)
            return {chip_mem[{a[10:0], 1'b0}], chip_mem[{a[10:0], 1'b1}]};
        if (a < 12'h880)
            return {disp_mem[{a[6:0], 1'b0}], disp_mem[{a[6:0], 1'b1}]};
        if (a == 12'h880) return ks;
        if (a == 12'hFFF) return st;
        return 16'h0000;
    endfunction

    function automatic int first_gnt(input logic [63:0] gv, input int from);
        for (int i = from; i < 64; i++) if (gv[i]) return i;
        return 63;
    endfunction

    function automatic int model_lat(input logic [11:0] a,
                                     input logic [63:0] gv);
        int f;
        if (a >= 12'h880) return 1;
        f = first_gnt(gv, 1);
        return first_gnt(gv, f + 1) + 2;
    endfunction

    function automatic logic [11:0] even_addr(input logic [11:0] a);
        if (a < 12'h800) return {a[10:0], 1'b0};
        return {4'h0, a[6:0], 1'b0};
    endfunction

    task automatic clear_tr();
        for (int i = 0; i < 64; i++) begin
            req_tr[i] = 1'b0;
            sel_tr[i] = 1'b0;
            adr_tr[i] = '0;
        end
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] ks,
                           input logic [15:0] st, output logic [15:0] data,
                           output int lat, output int pulses);
        int p0;
        clear_tr();
        p0 = pulse_cnt;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        keystate   = ks;
        status     = st;
        acc_cyc    = cyc;
        @(negedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        keystate   = 16'h0000;
        status     = 16'($urandom);
        lat = 1;
        while (!readdatavalid && lat < 80) begin
            @(negedge clk); #1;
            lat++;
        end
        data = readdata;
        @(negedge clk); #1;
        pulses = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        checks++;
        if (readdata !== 16'h0 || readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd got %h/%b want 0000/0",
                     readdata, readdatavalid);
        end
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got busy=%b req=%b sel=%b want 0",
                     busy, mem_req, mem_sel);
        end
        checks++;
        if (ch_addr !== 12'h0 || disp_addr !== 8'h0) begin
            errors++;
            $display("FAIL reset_addr got %h/%h want 000/00",
                     ch_addr, disp_addr);
        end
    endtask

    task automatic test_chip_ram();
        logic [15:0] d;
        int lat, p;
        chip_mem[12'h204] = 8'hA2;
        chip_mem[12'h205] = 8'h2A;
        gnt_vec = '1;
        do_read(12'h102, 16'h0, 16'h0, d, lat, p);
        checks++;
        if (d !== 16'hA22A) begin
            errors++;
            $display("FAIL chip_data got %h want a22a", d);
        end
        checks++;
        if (lat !== 4 || p !== 1) begin
            errors++;
            $display("FAIL chip_lat got %0d/%0d want 4/1", lat, p);
        end
        checks++;
        if (adr_tr[1] !== 12'h204 || adr_tr[2] !== 12'h205) begin
            errors++;
            $display("FAIL chip_addr got %h,%h want 204,205",
                     adr_tr[1], adr_tr[2]);
        end
        checks++;
        if (req_tr[1] !== 1'b1 || req_tr[2] !== 1'b1
            || req_tr[3] !== 1'b0) begin
            errors++;
            $display("FAIL chip_req got %b%b%b want 110",
                     req_tr[1], req_tr[2], req_tr[3]);
        end
    endtask

    task automatic test_disp_ram();
        logic [15:0] d;
        int lat, p;
        disp_mem[8'h1E] = 8'hF0;
        disp_mem[8'h1F] = 8'h0F;
        gnt_vec = '1;
        do_read(12'h80F, 16'h0, 16'h0, d, lat, p);
        checks++;
        if (d !== 16'hF00F || lat !== 4) begin
            errors++;
            $display("FAIL disp_data got %h lat %0d want f00f lat 4", d, lat);
        end
        checks++;
        if (sel_tr[1] !== 1'b1 || sel_tr[2] !== 1'b1) begin
            errors++;
            $display("FAIL disp_sel got %b%b want 11", sel_tr[1], sel_tr[2]);
        end
        checks++;
        if (adr_tr[1] !== 12'h01E || adr_tr[2] !== 12'h01F) begin
            errors++;
            $display("FAIL disp_addr got %h,%h want 01e,01f",
                     adr_tr[1], adr_tr[2]);
        end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        int lat, p;
        do_read(12'h880, 16'h8001, 16'h0, d, lat, p);
        checks++;
        if (d !== 16'h8001 || lat !== 1 || p !== 1) begin
            errors++;
            $display("FAIL key got %h lat %0d n %0d want 8001 1 1",
                     d, lat, p);
        end
        do_read(12'h900, 16'hFFFF, 16'hFFFF, d, lat, p);
        checks++;
        if (d !== 16'h0000 || lat !== 1) begin
            errors++;
            $display("FAIL unmapped got %h lat %0d want 0000 1", d, lat);
        end
        do_read(12'hFFF, 16'h0, 16'h0003, d, lat, p);
        checks++;
        if (d !== 16'h0003 || lat !== 1) begin
            errors++;
            $display("FAIL status got %h lat %0d want 0003 1", d, lat);
        end
    endtask

    task automatic test_stall();
        logic [15:0] d;
        logic [11:0] a;
        int lat, p, bad;
        a = 12'($urandom_range(0, 12'h7FF));
        gnt_vec = '1;
        gnt_vec[1] = 1'b0;
        gnt_vec[2] = 1'b0;
        gnt_vec[3] = 1'b0;
        gnt_vec[5] = 1'b0;
        gnt_vec[6] = 1'b0;
        do_read(a, 16'h0, 16'h0, d, lat, p);
        gnt_vec = '1;
        checks++;
        if (d !== model_word(a, 16'h0, 16'h0) || lat !== 9) begin
            errors++;
            $display("FAIL stall got %h lat %0d want %h lat 9",
                     d, lat, model_word(a, 16'h0, 16'h0));
        end
        bad = 0;
        for (int r = 1; r <= 7; r++) begin
            if (req_tr[r] !== 1'b1) bad++;
            if (adr_tr[r] !== (even_addr(a) | 12'(r > 4))) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_busy_drop();
        logic [11:0] a;
        int p0;
        a = 12'($urandom_range(0, 12'h7FF));
        gnt_vec = '1;
        clear_tr();
        p0 = pulse_cnt;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        acc_cyc    = cyc;
        @(negedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        @(negedge clk); #1;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 12'h880;
        keystate   = 16'hBEEF;
        @(negedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        keystate   = 16'h0;
        repeat (10) begin
            @(negedge clk); #1;
        end
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL drop_pulses got %0d want 1", pulse_cnt - p0);
        end
        checks++;
        if (readdata !== model_word(a, 16'h0, 16'h0)) begin
            errors++;
            $display("FAIL drop_data got %h want %h",
                     readdata, model_word(a, 16'h0, 16'h0));
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic [11:0] a;
        int lat, p, p0;
        do_read(12'h880, 16'h1234, 16'h0, d, lat, p);
        a = 12'($urandom_range(12'h800, 12'h87F));
        gnt_vec = '1;
        clear_tr();
        p0 = pulse_cnt;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        acc_cyc    = cyc;
        @(negedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({readdata, readdatavalid, busy, mem_req, mem_sel,
             ch_addr, disp_addr} !== '0) begin
            errors++;
            $display("FAIL midreset got rd=%h v=%b b=%b r=%b s=%b %h %h want 0",
                     readdata, readdatavalid, busy, mem_req, mem_sel,
                     ch_addr, disp_addr);
        end
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk); #1;
        end
        checks++;
        if (pulse_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL midreset_pulse got %0d want 0", pulse_cnt - p0);
        end
        a = 12'($urandom_range(0, 12'h7FF));
        do_read(a, 16'h0, 16'h0, d, lat, p);
        checks++;
        if (d !== model_word(a, 16'h0, 16'h0) || lat !== 4) begin
            errors++;
            $display("FAIL after_reset got %h lat %0d want %h lat 4",
                     d, lat, model_word(a, 16'h0, 16'h0));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        int lat, p;
        do_read(12'hFFF, 16'h0, 16'h5A5A, d, lat, p);
        do_read(12'h880, 16'h0F0F, 16'h0, d, lat, p);
        checks++;
        if (d !== 16'h0F0F || lat !== 1 || p !== 1) begin
            errors++;
            $display("FAIL b2b got %h lat %0d n %0d want 0f0f 1 1",
                     d, lat, p);
        end
    endtask

    task automatic test_random();
        logic [15:0] d, ks, st, w;
        logic [11:0] a;
        logic [63:0] gv;
        int lat, p, bad, f, el;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: a = 12'($urandom_range(0, 12'h7FF));
                1: a = 12'($urandom_range(12'h800, 12'h87F));
                2: a = 12'h880;
                3: a = 12'hFFF;
                default: a = 12'($urandom_range(12'h881, 12'hFFE));
            endcase
            ks = 16'($urandom);
            st = 16'($urandom);
            gv = {32'hFFFF_FFFF, 32'($urandom)};
            gnt_vec = gv;
            w  = model_word(a, ks, st);
            el = model_lat(a, gv);
            do_read(a, ks, st, d, lat, p);
            if (d !== w || lat !== el || p !== 1) begin
                bad++;
                $display("FAIL rand a=%h got %h lat %0d n %0d want %h lat %0d",
                         a, d, lat, p, w, el);
            end
            if (a < 12'h880) begin
                f = first_gnt(gv, 1);
                for (int r = 1; r <= el - 2; r++) begin
                    if (req_tr[r] !== 1'b1
                        || sel_tr[r] !== (a >= 12'h800)
                        || adr_tr[r] !== (even_addr(a) | 12'(r > f))) begin
                        bad++;
                        $display("FAIL rand_issue a=%h rel %0d got %b %b %h",
                                 a, r, req_tr[r], sel_tr[r], adr_tr[r]);
                    end
                end
            end
        end
        gnt_vec = '1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random got %0d bad reads want 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) chip_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) disp_mem[i] = 8'($urandom);
        reset      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
        keystate   = '0;
        status     = '0;
        clear_tr();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        test_chip_ram();
        test_disp_ram();
        test_regs();
        test_stall();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (glitch != 0) begin
            errors++;
            $display("FAIL readdata_hold got %0d changes without pulse want 0",
                     glitch);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_bus_reader.md
# chip8_bus_reader

Host read-back responder for the CHIP-8 peripheral, the read half of the host bus whose write half loads chip RAM, display RAM and control. It decodes 16-bit host reads against the peripheral map and competes for the chip/display RAM ports through the existing arbiter's request/grant pair. It assembles two big-endian bytes per word and returns them with a single-cycle `readdatavalid` pulse. It sits beside the write decoder in the top level and shares its `address` and `chipselect`.

## Interface
- No parameters.
- `clk` input 1: sole clock; all logic on rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `chipselect` input 1: peripheral selected.
- `read` input 1: read strobe, qualified by `chipselect`.
- `address` input 12: word address, same map as the write path.
- `readdata` output 16: response word; valid only while `readdatavalid`=1.
- `readdatavalid` output 1: one-cycle pulse per accepted read.
- `busy` output 1: a read is in flight; new reads are dropped.
- `mem_req` output 1: request a RAM byte read this cycle.
- `mem_gnt` input 1: arbiter grant; an issue happens on `mem_req`&&`mem_gnt`.
- `mem_sel` output 1: 0 = chip RAM, 1 = display RAM.
- `ch_addr` output 12: chip RAM byte address.
- `ch_q` input 8: chip RAM data, one cycle after issue.
- `disp_addr` output 8: display RAM byte address.
- `disp_q` input 8: display RAM data, one cycle after issue.
- `keystate` input 16: live keypad state, bit k = key k down.
- `status` input 16: control/status word.

## Operation
- Address map:
  - 0x000–0x7FF chip RAM: bytes {addr[10:0],0} and {addr[10:0],1}.
  - 0x800–0x87F display RAM: bytes {addr[6:0],0} and {addr[6:0],1}.
  - 0x880 keystate.
  - 0xFFF status.
  - Any other address reads as 0x0000.
- Byte order: even byte goes to `readdata[15:8]`, odd byte to `[7:0]`.
- Accept: in IDLE, `chipselect`&&`read` latches `address` and its region. `write` is ignored by this block. A read with `write` also high is still accepted.
- FSM states:
  - IDLE: accept a read. Register regions (keystate, status, unmapped) go to RESP; RAM regions go to ISSUE0.
  - ISSUE0: `mem_req`=1 with the even byte address. Hold until `mem_gnt`, then go to ISSUE1.
  - ISSUE1: `mem_req`=1 with the odd byte address. In the first cycle, capture the even byte from `ch_q`/`disp_q` per `mem_sel`. Hold until `mem_gnt`, then go to CAPT.
  - CAPT: capture the odd byte, then go to RESP.
  - RESP: `readdatavalid`=1 for one cycle, then go to IDLE.
- Register regions sample `keystate`/`status` in the accept cycle.
- Even-byte capture happens exactly once, in the cycle after the ISSUE0 grant, even if ISSUE1 then stalls.
- `mem_req` is low outside ISSUE0/ISSUE1. Addresses and `mem_sel` are stable for the whole of each ISSUE state.
- `busy`=1 in every state except IDLE. Reads arriving while `busy` are dropped and produce no response.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `busy`=0, `mem_req`=0, `mem_sel`=0, `ch_addr`=0, `disp_addr`=0. FSM resets to IDLE.
- Register-region latency: accept at cycle N, `readdatavalid` at N+1.
- RAM-region latency with `mem_gnt` held high: accept at N, issue even at N+1, issue odd at N+2, capture at N+3, `readdatavalid` at N+4.
- Each cycle `mem_gnt`=0 during ISSUE0/ISSUE1 adds exactly one cycle of latency.
- `readdata` holds its last value after the pulse. It changes only on the cycle that `readdatavalid` rises.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values. No `readdatavalid` pulse is emitted for the aborted read.
- Back-to-back reads: a read asserted in the cycle after RESP (FSM back in IDLE) is accepted.

## Test plan
- Chip RAM bytes 0x204=0xA2, 0x205=0x2A; read address 0x102 with grant tied high -> `readdata`=0xA22A, pulse 4 cycles after accept, `ch_addr` sequence 0x204 then 0x205.
- Display RAM bytes 0x1E=0xF0, 0x1F=0x0F; read 0x80F -> `mem_sel`=1, `disp_addr` 0x1E then 0x1F, `readdata`=0xF00F.
- `keystate`=0x8001 on the accept cycle and 0x0000 afterwards; read 0x880 -> `readdata`=0x8001 one cycle after accept. Read 0x900 -> 0x0000. Read 0xFFF with `status`=0x0003 -> 0x0003.
- `mem_gnt` low for 3 cycles in ISSUE0 and 2 cycles in ISSUE1 -> addresses held, correct word, pulse at N+9.
- A second read issued while `busy` -> dropped, exactly one pulse. Reset asserted in ISSUE1 -> no pulse, outputs zero next cycle, and the next read succeeds.
